// File: rtl/sample_delay_aligner.sv
// rtl/sample_delay_aligner.sv - runtime-programmable multi-channel IQ delay/alignment buffer
module sample_delay_aligner #(
  parameter int DW            = 32,
  parameter int N_CH          = 1,
  parameter int USER_DW       = 2,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 16,
  parameter int DEFAULT_MODE  = 0,
  localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DLY_W-1:0]     cfg_delay_i,
  input  logic                 cfg_mode_i,
  input  logic                 cfg_valid_i,
  input  logic [N_CH*DW-1:0]   s_axis_in_tdata,
  input  logic [USER_DW-1:0]   s_axis_in_tuser,
  input  logic                 s_axis_in_tvalid,
  output logic [N_CH*DW-1:0]   m_axis_out_tdata,
  output logic [USER_DW-1:0]   m_axis_out_tuser,
  output logic                 m_axis_out_tvalid,
  output logic                 primed_o,
  output logic [DLY_W-1:0]     cfg_delay_o,
  output logic                 cfg_clamped_o
);

  localparam int PTR_W   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int DATA_W  = N_CH * DW;
  localparam int ENTRY_W = DATA_W + USER_DW + 1;

  localparam logic [DLY_W-1:0] MAX_D    = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W:0]   MAX_D_X  = (DLY_W + 1)'(MAX_DELAY);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DELAY - 1);

  // Each entry is {valid, user, data}; contents are never reset, the fill count guards them.
  logic [ENTRY_W-1:0] mem_q [MAX_DELAY];

  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [DLY_W-1:0]   fill_q, fill_d;
  logic               mode_q, mode_d;
  logic               clamped_q, clamped_d;
  logic               primed_q, primed_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [USER_DW-1:0] out_user_q, out_user_d;

  logic [DLY_W-1:0]   req_delay;
  logic               req_out_of_range;
  logic               we;
  logic [DLY_W-1:0]   rd_back;
  logic [DLY_W:0]     rd_sum;
  logic [PTR_W-1:0]   rd_idx;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Clamp the requested delay into 1..MAX_DELAY and flag requests that needed it.
  always_comb begin
    req_delay        = cfg_delay_i;
    req_out_of_range = 1'b0;
    if (cfg_delay_i == '0) begin
      req_delay        = DLY_W'(1);
      req_out_of_range = 1'b1;
    end else if (cfg_delay_i > MAX_D) begin
      req_delay        = MAX_D;
      req_out_of_range = 1'b1;
    end
  end

  // A config strobe takes effect in its own cycle, so the coincident sample already uses it.
  always_comb begin
    delay_d   = cfg_valid_i ? req_delay : delay_q;
    mode_d    = cfg_valid_i ? cfg_mode_i : mode_q;
    clamped_d = cfg_valid_i && req_out_of_range;
    we        = (mode_d == 1'b0) || s_axis_in_tvalid;
    wr_d      = we ? ((wr_q == LAST_PTR) ? '0 : wr_q + PTR_W'(1)) : wr_q;
    in_entry  = {s_axis_in_tvalid, s_axis_in_tuser, s_axis_in_tdata};
  end

  // Read slot: cycle mode registers the entry that will be D cycles old next cycle (D-1 back,
  // or the live input when D is 1); sample mode reads D entries back before this write lands.
  always_comb begin
    rd_back = mode_d ? delay_d : (delay_d - DLY_W'(1));
    rd_sum  = (DLY_W + 1)'(wr_q) + MAX_D_X - {1'b0, rd_back};
    if (rd_sum >= MAX_D_X) begin
      rd_sum = rd_sum - MAX_D_X;
    end
    rd_idx   = rd_sum[PTR_W-1:0];
    rd_entry = mem_q[rd_idx];
    if (!mode_d && (delay_d == DLY_W'(1))) begin
      rd_entry = in_entry;
    end
  end

  // Fill tracking and output selection; a config strobe restarts the fill from this cycle.
  always_comb begin
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    if (!mode_d) begin
      if (cfg_valid_i) begin
        fill_d = DLY_W'(1);
      end else if (fill_q < delay_d) begin
        fill_d = fill_q + DLY_W'(1);
      end
      if (fill_d == delay_d) begin
        out_valid_d = rd_entry[ENTRY_W-1];
        out_data_d  = rd_entry[DATA_W-1:0];
        out_user_d  = rd_entry[DATA_W +: USER_DW];
      end
    end else begin
      if (cfg_valid_i) begin
        fill_d = s_axis_in_tvalid ? DLY_W'(1) : '0;
      end else if (s_axis_in_tvalid) begin
        if (fill_q == delay_d) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_entry[DATA_W-1:0];
          out_user_d  = rd_entry[DATA_W +: USER_DW];
        end else begin
          fill_d = fill_q + DLY_W'(1);
        end
      end
    end
    primed_d = (fill_d == delay_d);
  end

  // Control and output registers; reset discards everything buffered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q        <= '0;
      delay_q     <= DLY_W'(DEFAULT_DELAY);
      mode_q      <= 1'(DEFAULT_MODE);
      fill_q      <= '0;
      clamped_q   <= 1'b0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
    end else begin
      wr_q        <= wr_d;
      delay_q     <= delay_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      clamped_q   <= clamped_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
    end
  end

  // Circular buffer write port.
  always_ff @(posedge clk_i) begin
    if (!reset_i && we) begin
      mem_q[wr_q] <= in_entry;
    end
  end

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tuser  = out_user_q;
  assign m_axis_out_tvalid = out_valid_q;
  assign primed_o          = primed_q;
  assign cfg_delay_o       = delay_q;
  assign cfg_clamped_o     = clamped_q;

endmodule

// File: tb/tb_sample_delay_aligner.sv
// tb/tb_sample_delay_aligner.sv - directed self-checking bench for sample_delay_aligner
module tb_sample_delay_aligner;

  localparam int DW      = 8;
  localparam int N_CH    = 2;
  localparam int USER_DW = 2;
  localparam int MAXD    = 20;
  localparam int DLY_W   = 5;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic [DLY_W-1:0]     cfg_delay_i = '0;
  logic                 cfg_mode_i = 1'b0;
  logic                 cfg_valid_i = 1'b0;
  logic [N_CH*DW-1:0]   in_tdata = '0;
  logic [USER_DW-1:0]   in_tuser = '0;
  logic                 in_tvalid = 1'b0;
  logic [N_CH*DW-1:0]   out_tdata;
  logic [USER_DW-1:0]   out_tuser;
  logic                 out_tvalid;
  logic                 primed_o;
  logic [DLY_W-1:0]     cfg_delay_o;
  logic                 cfg_clamped_o;

  int n_assert = 0;
  int n_fail   = 0;

  sample_delay_aligner #(
    .DW(DW), .N_CH(N_CH), .USER_DW(USER_DW), .MAX_DELAY(MAXD),
    .DEFAULT_DELAY(16), .DEFAULT_MODE(0)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .cfg_delay_i(cfg_delay_i),
    .cfg_mode_i(cfg_mode_i),
    .cfg_valid_i(cfg_valid_i),
    .s_axis_in_tdata(in_tdata),
    .s_axis_in_tuser(in_tuser),
    .s_axis_in_tvalid(in_tvalid),
    .m_axis_out_tdata(out_tdata),
    .m_axis_out_tuser(out_tuser),
    .m_axis_out_tvalid(out_tvalid),
    .primed_o(primed_o),
    .cfg_delay_o(cfg_delay_o),
    .cfg_clamped_o(cfg_clamped_o)
  );

  always #5 clk = ~clk;

  // Channel 1 is a scrambled copy of channel 0 so a lane swap or mix is visible.
  function automatic logic [15:0] mk(input int x);
    logic [7:0] b;
    b = x[7:0];
    return {b ^ 8'hA5, b};
  endfunction

  function automatic logic [1:0] usr(input int x);
    return x[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x);
    in_tvalid = v;
    in_tdata  = mk(x);
    in_tuser  = usr(x);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int x);
    chk({tag, "_valid"}, 32'(out_tvalid), 32'(v));
    if (v) begin
      chk({tag, "_data"}, 32'(out_tdata), 32'(mk(x)));
      chk({tag, "_user"}, 32'(out_tuser), 32'(usr(x)));
    end
  endtask

  task automatic cfg(input int d, input logic m);
    cfg_valid_i = 1'b1;
    cfg_delay_i = DLY_W'(d);
    cfg_mode_i  = m;
  endtask

  bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset state
    drive(1'b1, 77);
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_tvalid", 32'(out_tvalid), 0);
    chk("rst_tdata", 32'(out_tdata), 0);
    chk("rst_tuser", 32'(out_tuser), 0);
    chk("rst_primed", 32'(primed_o), 0);
    chk("rst_cfg_delay", 32'(cfg_delay_o), 16);
    chk("rst_clamped", 32'(cfg_clamped_o), 0);

    // Mode 0, default D=16, continuous ramp; buffer of 20 wraps during the run
    for (int k = 0; k < 30; k++) begin
      drive(1'b1, k);
      tick();
      chk_out($sformatf("m0d16_%0d", k), k >= 15, k - 15);
      chk($sformatf("m0d16_primed_%0d", k), 32'(primed_o), 32'(k >= 15));
    end

    // Mode 0, D=5, valid pattern 1,0,1,1,0 with config coincident with first input
    for (int k = 0; k < 25; k++) begin
      if (k == 0) cfg(5, 1'b0);
      drive(pat[k % 5], 100 + k);
      tick();
      cfg_valid_i = 1'b0;
      if (k == 0) chk("m0d5_cfg_delay", 32'(cfg_delay_o), 5);
      chk_out($sformatf("m0d5_%0d", k), (k >= 4) ? pat[(k - 4) % 5] : 1'b0, 100 + k - 4);
    end

    // Mode 1, D=3, valid every 4th cycle, data 10..14
    cfg(3, 1'b1);
    drive(1'b0, 0);
    tick();
    cfg_valid_i = 1'b0;
    chk("m1d3_cfg_delay", 32'(cfg_delay_o), 3);
    chk("m1d3_flush_tvalid", 32'(out_tvalid), 0);
    chk("m1d3_flush_primed", 32'(primed_o), 0);
    for (int j = 0; j < 20; j++) begin
      drive(j % 4 == 0, 10 + j / 4);
      tick();
      chk_out($sformatf("m1d3_%0d", j), (j % 4 == 0) && (j / 4 >= 3), 10 + j / 4 - 3);
      if (j == 8) chk("m1d3_primed", 32'(primed_o), 1);
    end

    // Mode 0 reconfig 16 -> 4 coincident with a valid input
    for (int k = 0; k < 20; k++) begin
      if (k == 0) cfg(16, 1'b0);
      drive(1'b1, 150 + k);
      tick();
      cfg_valid_i = 1'b0;
    end
    chk_out("m0pre", 1'b1, 150 + 19 - 15);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) cfg(4, 1'b0);
      drive(1'b1, 200 + k);
      tick();
      cfg_valid_i = 1'b0;
      if (k == 0) begin
        chk("m0rc_cfg_delay", 32'(cfg_delay_o), 4);
        chk("m0rc_primed", 32'(primed_o), 0);
      end
      chk_out($sformatf("m0rc_%0d", k), k >= 3, 200 + k - 3);
    end

    // Mode 1 reconfig to D=4 coincident with a valid input, gaps every other cycle
    for (int j = 0; j < 16; j++) begin
      if (j == 0) cfg(4, 1'b1);
      drive(j % 2 == 0, 60 + j / 2);
      tick();
      cfg_valid_i = 1'b0;
      chk_out($sformatf("m1rc_%0d", j), (j % 2 == 0) && (j / 2 >= 4), 60 + j / 2 - 4);
    end

    // Mode 0, D=1: output follows input one cycle later
    for (int k = 0; k < 6; k++) begin
      if (k == 0) cfg(1, 1'b0);
      drive(k != 0, 80 + k);
      tick();
      cfg_valid_i = 1'b0;
      chk_out($sformatf("m0d1_%0d", k), k != 0, 80 + k);
    end

    // Clamping: 0 -> 1, 25 -> 20, 20 stays 20
    drive(1'b0, 0);
    cfg(0, 1'b0);
    tick();
    cfg_valid_i = 1'b0;
    chk("clamp0_delay", 32'(cfg_delay_o), 1);
    chk("clamp0_pulse", 32'(cfg_clamped_o), 1);
    tick();
    chk("clamp0_pulse_end", 32'(cfg_clamped_o), 0);
    cfg(25, 1'b1);
    tick();
    cfg_valid_i = 1'b0;
    chk("clamp25_delay", 32'(cfg_delay_o), 20);
    chk("clamp25_pulse", 32'(cfg_clamped_o), 1);
    tick();
    chk("clamp25_pulse_end", 32'(cfg_clamped_o), 0);
    cfg(20, 1'b1);
    tick();
    cfg_valid_i = 1'b0;
    chk("noclamp20_delay", 32'(cfg_delay_o), 20);
    chk("noclamp20_pulse", 32'(cfg_clamped_o), 0);

    // Mode 1, D=MAX: output k equals input k-20 across several wraps
    for (int k = 0; k < 45; k++) begin
      drive(1'b1, 30 + k);
      tick();
      chk_out($sformatf("m1max_%0d", k), k >= 20, 30 + k - 20);
    end
    chk("m1max_primed", 32'(primed_o), 1);

    // Reset mid-stream
    reset_i = 1'b1;
    drive(1'b1, 99);
    tick();
    reset_i = 1'b0;
    chk("rst2_tvalid", 32'(out_tvalid), 0);
    chk("rst2_tdata", 32'(out_tdata), 0);
    chk("rst2_tuser", 32'(out_tuser), 0);
    chk("rst2_primed", 32'(primed_o), 0);
    chk("rst2_cfg_delay", 32'(cfg_delay_o), 16);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 240 + k);
      tick();
      chk($sformatf("rst2_nostale_%0d", k), 32'(out_tvalid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
